instr_enc: RTL and testbench

- Instruction encoder: the inverse of Instr_Dec. Packs decoded RV32I fields (op, rd, funct3, rs1, rs2, funct7, imm) back into a 32-bit instruction word.
- Validates the opcode and immediate range, tags each legal word with an instruction-memory byte address, and buffers results in a small output FIFO with valid/ready on both sides.
- Sits between the test-program generator / debug loader and the instruction-memory write port.

---
 rtl/rv32_pkg.sv | 32 +++
 rtl/instr_fifo.sv | 80 ++++++++
 rtl/instr_enc.sv | 152 +++++++++++++++
 tb/tb_instr_enc.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32I constants shared by the instruction encoder and decoder.
//   - base opcode values
//   - instruction format enum and output FIFO occupancy enum
//   - legal immediate ranges per format
package rv32_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // funct3 values that turn OP_IMM into a shift-immediate
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    typedef enum logic [1:0] {OCC_EMPTY, OCC_PART, OCC_FULL} occ_e;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: DEPTH x W output buffer with count-based full/empty.
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous clear, wins over push/pop
//   push, wr_data   write request (ignored when full)
//   pop             read request (ignored when empty)
//   empty, full     occupancy flags
//   rd_data         head entry
module instr_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 42
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic         empty,
    output logic         full,
    output logic [W-1:0] rd_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q, count_d;
    occ_e          occ_q, occ_d;
    logic          push_ok, pop_ok;

    assign empty   = (occ_q == OCC_EMPTY);
    assign full    = (occ_q == OCC_FULL);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
        occ_d = OCC_PART;
        if (count_d == '0) begin
            occ_d = OCC_EMPTY;
        end else if (count_d == CW'(DEPTH)) begin
            occ_d = OCC_FULL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            occ_q   <= OCC_EMPTY;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            count_q <= count_d;
            occ_q   <= occ_d;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PW'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/instr_enc.sv
// instr_enc: packs decoded RV32I fields into a 32-bit instruction word,
// rejects illegal opcodes/immediates, tags legal words with a byte address
// and buffers them in an output FIFO.
//   clk, I_rst_n       clock, asynchronous active-low reset
//   I_flush            synchronous FIFO clear + address restore
//   I_valid/O_ready    field bundle handshake
//   I_op..I_imm        decoded fields (I_imm sign-extended)
//   O_valid/I_ready    FIFO head handshake
//   O_instr, O_addr    head word and its byte address
//   O_err, O_err_cnt   reject pulse and saturating reject count
module instr_enc
    import rv32_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 2
) (
    input  logic              clk,
    input  logic              I_rst_n,
    input  logic              I_flush,
    input  logic              I_valid,
    output logic              O_ready,
    input  logic [6:0]        I_op,
    input  logic [4:0]        I_rd,
    input  logic [2:0]        I_funct3,
    input  logic [4:0]        I_rs1,
    input  logic [4:0]        I_rs2,
    input  logic [6:0]        I_funct7,
    input  logic [31:0]       I_imm,
    output logic              O_valid,
    input  logic              I_ready,
    output logic [31:0]       O_instr,
    output logic [ADDR_W-1:0] O_addr,
    output logic              O_err,
    output logic [7:0]        O_err_cnt
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

    fmt_e               fmt;
    logic               op_ok, imm_ok, is_shift, legal;
    logic               accept, push, reject;
    logic signed [31:0] imm_s;
    logic [31:0]        word;
    logic               rdy_q, err_q, fifo_empty, fifo_full;
    logic [7:0]         err_cnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31+ADDR_W:0] head;

    assign imm_s    = I_imm;
    assign is_shift = (I_op == OP_IMM) && (I_funct3 == F3_SLL || I_funct3 == F3_SRX);

    always_comb begin
        fmt   = FMT_R;
        op_ok = 1'b1;
        case (I_op)
            OP_R:                     fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
            OP_STORE:                 fmt = FMT_S;
            OP_BRANCH:                fmt = FMT_B;
            OP_LUI, OP_AUIPC:         fmt = FMT_U;
            OP_JAL:                   fmt = FMT_J;
            default:                  op_ok = 1'b0;
        endcase
    end

    always_comb begin
        word   = '0;
        imm_ok = 1'b1;
        case (fmt)
            FMT_R: word = {I_funct7, I_rs2, I_rs1, I_funct3, I_rd, I_op};
            FMT_I: begin
                if (is_shift) begin
                    word   = {I_funct7, I_imm[4:0], I_rs1, I_funct3, I_rd, I_op};
                    imm_ok = (I_imm[31:5] == '0);
                end else begin
                    word   = {I_imm[11:0], I_rs1, I_funct3, I_rd, I_op};
                    imm_ok = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
                end
            end
            FMT_S: begin
                word   = {I_imm[11:5], I_rs2, I_rs1, I_funct3, I_imm[4:0], I_op};
                imm_ok = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
            end
            FMT_B: begin
                word   = {I_imm[12], I_imm[10:5], I_rs2, I_rs1, I_funct3,
                          I_imm[4:1], I_imm[11], I_op};
                imm_ok = (imm_s >= IMM_B_MIN) && (imm_s <= IMM_B_MAX) && !I_imm[0];
            end
            FMT_U: begin
                word   = {I_imm[31:12], I_rd, I_op};
                imm_ok = (I_imm[11:0] == '0);
            end
            FMT_J: begin
                word   = {I_imm[20], I_imm[10:1], I_imm[11], I_imm[19:12], I_rd, I_op};
                imm_ok = (imm_s >= IMM_J_MIN) && (imm_s <= IMM_J_MAX) && !I_imm[0];
            end
            default: imm_ok = 1'b0;
        endcase
    end

    // a bundle offered during flush is consumed but neither pushed nor counted
    assign legal   = op_ok && imm_ok;
    assign O_ready = rdy_q && !fifo_full;
    assign accept  = I_valid && O_ready && !I_flush;
    assign push    = accept && legal;
    assign reject  = accept && !legal;

    always_ff @(posedge clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rdy_q     <= 1'b0;
            addr_q    <= BASE;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            rdy_q <= 1'b1;
            err_q <= reject;
            if (I_flush) begin
                addr_q <= BASE;
            end else if (push) begin
                addr_q <= addr_q + STEP;
            end
            if (reject && err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (32 + ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (I_rst_n),
        .flush   (I_flush),
        .push    (push),
        .wr_data ({word, addr_q}),
        .pop     (I_ready),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .rd_data (head)
    );

    // head fields are masked while empty so reset/flush show the idle values
    assign O_valid   = !fifo_empty;
    assign O_instr   = fifo_empty ? '0 : head[31+ADDR_W:ADDR_W];
    assign O_addr    = fifo_empty ? BASE : head[ADDR_W-1:0];
    assign O_err     = err_q;
    assign O_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_instr_enc.sv
module tb_instr_enc;

    localparam int ADDR_W = 10;
    localparam int BASE   = 0;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              I_rst_n, I_flush, I_valid, O_ready, O_valid, I_ready, O_err;
    logic [6:0]        I_op, I_funct7;
    logic [4:0]        I_rd, I_rs1, I_rs2;
    logic [2:0]        I_funct3;
    logic [31:0]       I_imm, O_instr;
    logic [ADDR_W-1:0] O_addr;
    logic [7:0]        O_err_cnt;

    always #5 clk = ~clk;

    instr_enc #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .I_rst_n   (I_rst_n),
        .I_flush   (I_flush),
        .I_valid   (I_valid),
        .O_ready   (O_ready),
        .I_op      (I_op),
        .I_rd      (I_rd),
        .I_funct3  (I_funct3),
        .I_rs1     (I_rs1),
        .I_rs2     (I_rs2),
        .I_funct7  (I_funct7),
        .I_imm     (I_imm),
        .O_valid   (O_valid),
        .I_ready   (I_ready),
        .O_instr   (O_instr),
        .O_addr    (O_addr),
        .O_err     (O_err),
        .O_err_cnt (O_err_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: returns {legal, word}, built from field positions.
    function automatic logic [32:0] model_enc(input logic [6:0] op, input logic [4:0] rd,
                                              input logic [2:0] f3, input logic [4:0] rs1,
                                              input logic [4:0] rs2, input logic [6:0] f7,
                                              input logic [31:0] imm);
        int          v;
        logic        ok;
        logic [31:0] w, lo, dst;
        v   = imm;
        ok  = 1'b1;
        lo  = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        dst = 32'(rd) << 7;
        case (op)
            7'h33: w = (32'(f7) << 25) | (32'(rs2) << 20) | lo | dst;
            7'h13, 7'h03, 7'h67: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    ok = (imm < 32);
                    w  = (32'(f7) << 25) | ((imm % 32) << 20) | lo | dst;
                end else begin
                    ok = (v >= -2048) && (v <= 2047);
                    w  = ((imm % 4096) << 20) | lo | dst;
                end
            end
            7'h23: begin
                ok = (v >= -2048) && (v <= 2047);
                w  = (((imm / 32) % 128) << 25) | (32'(rs2) << 20) | lo | ((imm % 32) << 7);
            end
            7'h63: begin
                ok = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
                w  = (((imm >> 12) & 1) << 31) | (((imm >> 5) % 64) << 25) | (32'(rs2) << 20)
                     | lo | (((imm >> 1) % 16) << 8) | (((imm >> 11) & 1) << 7);
            end
            7'h37, 7'h17: begin
                ok = (imm % 4096 == 0);
                w  = (imm - imm % 4096) | dst | 32'(op);
            end
            7'h6F: begin
                ok = (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
                w  = (((imm >> 20) & 1) << 31) | (((imm >> 1) % 1024) << 21)
                     | (((imm >> 11) & 1) << 20) | (((imm >> 12) % 256) << 12) | dst | 32'(op);
            end
            default: begin
                ok = 1'b0;
                w  = '0;
            end
        endcase
        return {ok, w};
    endfunction

    typedef struct {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] addr;
    } ent_t;

    ent_t              q[$];
    logic              m_rdy;
    logic              m_err;
    logic [ADDR_W-1:0] m_addr;
    int                m_cnt;

    // Transaction-level model of the encoder and its FIFO.
    always @(posedge clk or negedge I_rst_n) begin : model
        logic        rdy_now;
        logic [32:0] e;
        if (!I_rst_n) begin
            q.delete();
            m_rdy  = 1'b0;
            m_err  = 1'b0;
            m_addr = ADDR_W'(BASE);
            m_cnt  = 0;
        end else begin
            rdy_now = m_rdy && (q.size() < DEPTH);
            m_err   = 1'b0;
            if (I_flush) begin
                q.delete();
                m_addr = ADDR_W'(BASE);
            end else begin
                if (I_ready && q.size() > 0) void'(q.pop_front());
                if (I_valid && rdy_now) begin
                    e = model_enc(I_op, I_rd, I_funct3, I_rs1, I_rs2, I_funct7, I_imm);
                    if (e[32]) begin
                        q.push_back(ent_t'{e[31:0], m_addr});
                        m_addr = m_addr + ADDR_W'(4);
                    end else begin
                        m_err = 1'b1;
                        if (m_cnt < 255) m_cnt++;
                    end
                end
            end
            m_rdy = 1'b1;
        end
    end

    // Compare process: outputs against the model every cycle.
    always @(negedge clk) begin
        chk("ready", O_ready, m_rdy && (q.size() < DEPTH));
        chk("valid", O_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("instr", O_instr, q[0].instr);
            chk("addr", O_addr, q[0].addr);
        end else if (!I_rst_n) begin
            chk("rst_instr", O_instr, 0);
            chk("rst_addr", O_addr, BASE);
        end
        chk("err", O_err, m_err);
        chk("err_cnt", O_err_cnt, m_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
                         input logic [31:0] imm);
        I_valid  = 1'b1;
        I_op     = op;
        I_rd     = rd;
        I_funct3 = f3;
        I_rs1    = rs1;
        I_rs2    = rs2;
        I_funct7 = f7;
        I_imm    = imm;
    endtask

    task automatic do_flush();
        I_valid = 1'b0;
        I_flush = 1'b1;
        tick();
        I_flush = 1'b0;
    endtask

    function automatic logic [31:0] rand_imm();
        int edges [14] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098,
                           1048574, 1048576, -1048576, 31, 32};
        case ($urandom_range(0, 6))
            0: return 32'($urandom_range(0, 4095)) - 32'd2048;
            1: return $urandom;
            2: return (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
            3: return $urandom & 32'hFFFFF000;
            4: return (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
            5: return 32'($urandom_range(0, 40));
            default: return edges[$urandom_range(0, 13)];
        endcase
    endfunction

    logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    logic [32:0] pin;

    initial begin
        I_rst_n = 1'b0;
        I_flush = 1'b0;
        I_ready = 1'b1;
        offer(7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        I_valid = 1'b0;

        // literal pins for the reference encoder
        pin = model_enc(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
        chk("model_add", pin, {1'b1, 32'h002081B3});
        pin = model_enc(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFFFFFC);
        chk("model_beq", pin, {1'b1, 32'hFE208EE3});
        pin = model_enc(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd8);
        chk("model_jal", pin, {1'b1, 32'h008000EF});
        pin = model_enc(7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
        chk("model_addi_bad", pin[32], 1'b0);

        // reset values
        #12;
        chk("rst_valid", O_valid, 0);
        chk("rst_ready", O_ready, 0);
        chk("rst_errcnt", O_err_cnt, 0);
        @(posedge clk);
        #2;
        I_rst_n = 1'b1;
        tick();
        chk("ready_after_rst", O_ready, 1);

        // ADD x3,x1,x2
        offer(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
        tick();
        I_valid = 1'b0;
        #1;
        chk("add_valid", O_valid, 1);
        chk("add_instr", O_instr, 32'h002081B3);
        chk("add_addr", O_addr, 0);
        tick();

        // BEQ then JAL
        do_flush();
        I_ready = 1'b0;
        offer(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFFFFFC);
        tick();
        offer(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd8);
        tick();
        I_valid = 1'b0;
        chk("beq_instr", O_instr, 32'hFE208EE3);
        chk("beq_addr", O_addr, 0);
        I_ready = 1'b1;
        tick();
        chk("jal_instr", O_instr, 32'h008000EF);
        chk("jal_addr", O_addr, 4);
        tick();

        // ADDI -1, then an out-of-range ADDI
        do_flush();
        I_ready = 1'b0;
        offer(7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFF);
        tick();
        chk("addi_instr", O_instr, 32'hFFF00293);
        offer(7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
        tick();
        chk("addi_err", O_err, 1);
        chk("addi_errcnt", O_err_cnt, 1);
        offer(7'h13, 5'd6, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        tick();
        chk("err_pulse_end", O_err, 0);
        I_valid = 1'b0;
        I_ready = 1'b1;
        tick();
        chk("after_reject_addr", O_addr, 4);
        tick();

        // backpressure: third bundle held while full
        do_flush();
        I_ready = 1'b0;
        offer(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
        tick();
        offer(7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2);
        tick();
        chk("full_ready", O_ready, 0);
        offer(7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3);
        tick();
        chk("held_ready", O_ready, 0);
        chk("held_addr", O_addr, 0);
        I_ready = 1'b1;
        tick();
        chk("drain1_addr", O_addr, 4);
        tick();
        chk("drain2_addr", O_addr, 8);
        I_valid = 1'b0;
        tick();
        chk("drained", O_valid, 0);

        // flush with two entries, then reset mid-drain
        I_ready = 1'b0;
        offer(7'h37, 5'd4, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000);
        tick();
        tick();
        do_flush();
        chk("flush_valid", O_valid, 0);
        offer(7'h17, 5'd4, 3'd0, 5'd0, 5'd0, 7'd0, 32'hABCDE000);
        tick();
        chk("post_flush_addr", O_addr, BASE);
        tick();
        I_valid = 1'b0;
        I_ready = 1'b1;
        tick();
        I_rst_n = 1'b0;
        #1;
        chk("arst_valid", O_valid, 0);
        chk("arst_instr", O_instr, 0);
        chk("arst_addr", O_addr, BASE);
        chk("arst_errcnt", O_err_cnt, 0);
        chk("arst_ready", O_ready, 0);
        tick();
        I_rst_n = 1'b1;
        tick();

        // address wrap
        offer(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
        for (int i = 0; i < 256; i++) begin
            tick();
            if (i == 255) chk("wrap_last", O_addr, 10'h3FC);
        end
        tick();
        chk("wrap_zero", O_addr, 0);
        I_valid = 1'b0;
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            I_flush = ($urandom_range(0, 39) == 0);
            I_ready = ($urandom_range(0, 9) < 7);
            offer(($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)],
                  5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
                  7'($urandom), rand_imm());
            I_valid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 999) == 0) I_rst_n = 1'b0;
            tick();
            I_rst_n = 1'b1;
        end
        I_flush = 1'b0;
        I_valid = 1'b0;
        tick();

        // error counter saturation
        I_ready = 1'b1;
        offer(7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        for (int i = 0; i < 300; i++) tick();
        I_valid = 1'b0;
        chk("errcnt_sat", O_err_cnt, 255);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
